// File: rtl/compression_packer.sv
// compression_packer: concatenates variable-length symbols MSB-first into
// AHB_WIDTH-bit words. The accumulator is left-justified; full words are peeled
// off the top into a single output register. A flush drains the residual bits
// as a zero-padded final word tagged with out_last.
module compression_packer #(
  parameter int AHB_WIDTH = 32,
  parameter int MAX_SYM   = 16,
  parameter int LEN_W     = $clog2(MAX_SYM + 1),
  parameter int CNT_W     = $clog2(AHB_WIDTH + MAX_SYM + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_SYM-1:0]   in_data,
  input  logic [LEN_W-1:0]     in_len,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AHB_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 flush_done,
  output logic [CNT_W-1:0]     fill_level
);

  localparam int ACC_W = AHB_WIDTH + MAX_SYM;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   out_valid_q, out_valid_d;
  logic [AHB_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;

  logic [LEN_W-1:0]       len_eff;
  logic [MAX_SYM:0]       len_onehot;
  logic [MAX_SYM-1:0]     sym_masked;
  logic [CNT_W-1:0]       ins_shamt;
  logic [ACC_W-1:0]       sym_placed;
  logic                   sym_fire;
  logic                   reg_free;
  logic                   full_load;
  logic                   resid_load;

  // Symbol alignment: clamp length, mask unused bits, slide the symbol to sit
  // directly below the bits already held.
  always_comb begin
    len_eff    = (in_len > LEN_W'(MAX_SYM)) ? LEN_W'(MAX_SYM) : in_len;
    len_onehot = (MAX_SYM + 1)'(1) << len_eff;
    sym_masked = in_data & MAX_SYM'(len_onehot - (MAX_SYM + 1)'(1));
    ins_shamt  = CNT_W'(ACC_W) - count_q - CNT_W'(len_eff);
    sym_placed = ACC_W'(sym_masked) << ins_shamt;
    sym_fire   = in_valid & in_ready;
    reg_free   = !out_valid_q || out_ready;
    // count < AHB_WIDTH whenever a symbol is accepted, so a load and an
    // insert never collide in the same cycle.
    full_load  = (count_q >= CNT_W'(AHB_WIDTH)) && reg_free;
    resid_load = (state_q == DRAIN) && (count_q != '0) &&
                 (count_q < CNT_W'(AHB_WIDTH)) && reg_free;
  end

  // State and datapath registers; reset drops any buffered bits and pending word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state: flush only honoured in RUN; DRAIN ends once nothing is
  // buffered and the output register is empty or emptying this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if ((count_q == '0) && reg_free) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Accumulator / output register update. Bits below count are always zero,
  // so the residual word is already zero-padded when taken from the top.
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (state_q == DONE) begin
      acc_d   = '0;
      count_d = '0;
    end else if (full_load) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q[ACC_W-1 -: AHB_WIDTH];
      out_last_d  = (state_q == DRAIN) && (count_q == CNT_W'(AHB_WIDTH));
      acc_d       = acc_q << AHB_WIDTH;
      count_d     = count_q - CNT_W'(AHB_WIDTH);
    end else if (resid_load) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q[ACC_W-1 -: AHB_WIDTH];
      out_last_d  = 1'b1;
      acc_d       = '0;
      count_d     = '0;
    end else if (sym_fire) begin
      acc_d   = acc_q | sym_placed;
      count_d = count_q + CNT_W'(len_eff);
    end
  end

  // Outputs: handshake readiness, flush completion pulse and status.
  always_comb begin
    in_ready   = (state_q == RUN) && (count_q < CNT_W'(AHB_WIDTH));
    flush_done = (state_q == DONE);
    out_valid  = out_valid_q;
    out_data   = out_data_q;
    out_last   = out_last_q;
    fill_level = count_q;
  end

endmodule

// File: tb/tb_compression_packer.sv
// Scoreboard bench for compression_packer: a bit-queue reference model turns
// accepted symbols into expected words; a negedge monitor pops and compares.
module tb_compression_packer;
  localparam int AW = 32;
  localparam int MS = 16;
  localparam int LW = $clog2(MS + 1);
  localparam int CW = $clog2(AW + MS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MS-1:0] in_data = '0;
  logic [LW-1:0] in_len = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_last;
  logic          flush_done;
  logic [CW-1:0] fill_level;

  compression_packer #(.AHB_WIDTH(AW), .MAX_SYM(MS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .flush_done(flush_done), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] data; logic last; } word_t;

  word_t exp_q[$];
  bit    bitq[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    fd_cnt = 0;
  int    fd_exp = 0;
  bit    mon_en = 1'b0;
  bit    rnd_or = 1'b0;
  bit    or_force = 1'b1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: symbols are a bit stream cut every AW bits; a flush pads
  // the remainder and tags the last word produced from the flushed bits.
  task automatic model_push(logic [MS-1:0] d, int len, bit fl);
    word_t loc[$];
    word_t w;
    int    l;
    l = (len > MS) ? MS : len;
    for (int i = l - 1; i >= 0; i--) bitq.push_back(d[i]);
    while (bitq.size() >= AW) begin
      for (int i = AW - 1; i >= 0; i--) w.data[i] = bitq.pop_front();
      w.last = 1'b0;
      loc.push_back(w);
    end
    if (fl && bitq.size() > 0) begin
      w.data = '0;
      for (int i = AW - 1; i >= 0 && bitq.size() > 0; i--) w.data[i] = bitq.pop_front();
      w.last = 1'b0;
      loc.push_back(w);
    end
    if (fl && loc.size() > 0) loc[loc.size()-1].last = 1'b1;
    foreach (loc[k]) exp_q.push_back(loc[k]);
  endtask

  // out_ready source: forced level or random backpressure.
  always @(posedge clk) begin
    #1 out_ready = rnd_or ? ($urandom_range(0, 3) != 0) : or_force;
  end
  initial out_ready = 1'b1;

  // Monitor: compares every output handshake and checks stability under stall.
  logic [AW-1:0] prev_d;
  logic          prev_l;
  bit            prev_stall = 1'b0;
  bit            fd_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst || !mon_en) begin
      prev_stall = 1'b0;
      fd_prev = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", out_data, prev_d);
        chk("hold_last", out_last, prev_l);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", out_data, 64'hx);
        else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word_data", out_data, w.data);
          chk("word_last", out_last, w.last);
        end
      end
      if (flush_done) begin
        fd_cnt++;
        chk("flush_done_width", {fd_prev, flush_done}, 2'b01);
      end
      fd_prev    = flush_done;
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
    end
  end

  // Present one symbol (v) and/or flush (fl); waits for in_ready.
  task automatic send(logic [MS-1:0] d, int len, bit v, bit fl);
    int budget;
    bit done;
    budget = 300;
    done = 1'b0;
    in_valid = v;
    in_data = d;
    in_len = LW'(len);
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        flush = fl;
        if (v || fl) model_push(d, v ? len : 0, fl);
        if (fl) fd_exp++;
        done = 1'b1;
      end else if (--budget == 0) begin
        chk("send_timeout", in_ready, 1);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int b;
    b = 2000;
    while ((exp_q.size() != 0 || !in_ready) && b > 0) begin
      @(posedge clk); #1; b--;
    end
    if (b == 0) chk("drain_timeout", exp_q.size(), 0);
    idle(3);
    chk("flush_done_count", fd_cnt, fd_exp);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_flush_done"}, flush_done, 0);
    chk({tag, "_fill_level"}, fill_level, 0);
  endtask

  initial begin
    idle(2);
    #1 chk_reset("reset");
    @(posedge clk); #1 rst = 1'b1;
    mon_en = 1'b1;

    // DC alignment
    send(16'h1234, 16, 1, 0);
    send(16'hABCD, 16, 1, 0);
    idle(4);
    chk("dc_fill_level", fill_level, bitq.size());
    chk("dc_words_left", exp_q.size(), 0);

    // Mixed lengths then flush
    send(16'hABCD, 16, 1, 0);
    send(16'h0EF1, 12, 1, 0);
    send(16'h0234, 12, 1, 0);
    send(16'h0567, 12, 1, 0);
    send(16'h0000, 0, 0, 1);
    wait_drain();

    // Masking, zero lengths, over-long length clamped to MAX_SYM
    send(16'hFFF5, 4, 1, 0);
    for (int i = 0; i < 8; i++) send(16'hFFFF, 0, 1, 0);
    send(16'h1234, 20, 1, 0);
    send(16'hF567, 12, 1, 0);
    idle(4);
    chk("mask_fill_level", fill_level, 0);
    chk("mask_words_left", exp_q.size(), 0);

    // Backpressure
    or_force = 1'b0;
    idle(1);
    send(16'h1111, 16, 1, 0);
    send(16'h2222, 16, 1, 0);
    send(16'h3333, 16, 1, 0);
    send(16'h4444, 16, 1, 0);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_fill_level", fill_level, 32);
    chk("bp_out_data", out_data, 32'h11112222);
    idle(5);
    or_force = 1'b1;
    idle(6);
    chk("bp_words_left", exp_q.size(), 0);

    // Empty flush
    send(16'h0000, 0, 0, 1);
    @(negedge clk);
    chk("ef_in_ready_1", in_ready, 0);
    chk("ef_fd_1", flush_done, 0);
    chk("ef_ov_1", out_valid, 0);
    @(negedge clk);
    chk("ef_in_ready_2", in_ready, 0);
    chk("ef_fd_2", flush_done, 1);
    chk("ef_ov_2", out_valid, 0);
    @(negedge clk);
    chk("ef_in_ready_3", in_ready, 1);
    chk("ef_fd_3", flush_done, 0);
    idle(1);
    chk("ef_fd_count", fd_cnt, fd_exp);

    // Reset mid-stream with a held output word and 20 buffered bits
    or_force = 1'b0;
    idle(1);
    send(16'h1111, 16, 1, 0);
    send(16'h2222, 16, 1, 0);
    send(16'hABCD, 16, 1, 0);
    send(16'h0005, 4, 1, 0);
    idle(1);
    chk("rm_pre_out_valid", out_valid, 1);
    chk("rm_pre_fill", fill_level, 20);
    mon_en = 1'b0;
    rst = 1'b0;
    #1 chk_reset("midrst");
    exp_q.delete();
    bitq.delete();
    @(posedge clk); #1 rst = 1'b1;
    or_force = 1'b1;
    mon_en = 1'b1;
    send(16'hDEAD, 16, 1, 0);
    send(16'hBEEF, 16, 1, 0);
    idle(4);
    chk("rm_words_left", exp_q.size(), 0);

    // Random traffic with random backpressure and occasional flushes
    rnd_or = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(MS'($urandom), $urandom_range(0, 20),
           $urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0);
    end
    send(16'h0000, 0, 0, 1);
    wait_drain();
    rnd_or = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
